// File: rtl/seg_pkg.sv
// Shared seven-segment pattern constants and classifier used by both the
// digit encoder and the receive-side decode monitor.
package seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Bit order {a,b,c,d,e,f,g}, active high.
  localparam seg_t SEG_DIGIT0 = 7'b1111110;
  localparam seg_t SEG_DIGIT1 = 7'b0110000;
  localparam seg_t SEG_DIGIT2 = 7'b1101101;
  localparam seg_t SEG_DIGIT3 = 7'b1111001;
  localparam seg_t SEG_DIGIT4 = 7'b0110011;
  localparam seg_t SEG_DIGIT5 = 7'b1011011;
  localparam seg_t SEG_DIGIT6 = 7'b1011111;
  localparam seg_t SEG_DIGIT7 = 7'b1110000;
  localparam seg_t SEG_BLANK  = 7'b0000000;

  typedef struct packed {
    logic       is_digit;
    logic       is_blank;
    logic [2:0] digit;
  } seg_decode_t;

  function automatic seg_decode_t seg_classify(input seg_t s);
    seg_decode_t r;
    r = '{is_digit: 1'b1, is_blank: 1'b0, digit: 3'd0};
    case (s)
      SEG_DIGIT0: r.digit = 3'd0;
      SEG_DIGIT1: r.digit = 3'd1;
      SEG_DIGIT2: r.digit = 3'd2;
      SEG_DIGIT3: r.digit = 3'd3;
      SEG_DIGIT4: r.digit = 3'd4;
      SEG_DIGIT5: r.digit = 3'd5;
      SEG_DIGIT6: r.digit = 3'd6;
      SEG_DIGIT7: r.digit = 3'd7;
      SEG_BLANK: begin
        r.is_digit = 1'b0;
        r.is_blank = 1'b1;
      end
      default: r.is_digit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational classifier: segment pattern to {is_digit, is_blank, digit}.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             is_digit,
  output logic             is_blank,
  output logic [2:0]       digit
);

  seg_decode_t dec;

  always_comb begin
    dec      = seg_classify(seg);
    is_digit = dec.is_digit;
    is_blank = dec.is_blank;
    digit    = dec.digit;
  end

endmodule

// File: rtl/seg_decode_monitor.sv
// Seven-segment receive monitor: debounces the segment bus, emits one event per
// stable pattern and keeps saturating per-digit and invalid-pattern counts.
module seg_decode_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg,
  input  logic             clear,
  input  logic [2:0]       rd_sel,
  output logic [2:0]       digit,
  output logic             digit_valid,
  output logic             invalid,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] invalid_count
);

  localparam logic [7:0]       RUN_ACCEPT = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RUN_MAX    = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [SEG_W-1:0] seg_q;
  logic [7:0]       run_len;
  logic             is_digit;
  logic             is_blank;
  logic [2:0]       dec_digit;
  logic             accept;
  logic             valid_ev;
  logic             invalid_ev;
  logic [CNT_W-1:0] hist [8];

  seg_pattern_decode u_decode (
    .seg      (seg),
    .is_digit (is_digit),
    .is_blank (is_blank),
    .digit    (dec_digit)
  );

  // run_len saturates at STABLE_CYCLES, so this fires once per stable run
  always_comb begin
    accept     = (seg == seg_q) && (run_len == RUN_ACCEPT);
    valid_ev   = accept && is_digit;
    invalid_ev = accept && !is_digit && !is_blank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= '0;
      run_len <= 8'd0;
    end else begin
      seg_q <= seg;
      if (seg != seg_q) begin
        run_len <= 8'd1;
      end else if (run_len < RUN_MAX) begin
        run_len <= run_len + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit       <= 3'd0;
      digit_valid <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      digit_valid <= valid_ev;
      invalid     <= invalid_ev;
      if (valid_ev) begin
        digit <= dec_digit;
      end
    end
  end

  // clear takes priority over a coinciding event
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 8; i++) begin
        hist[i] <= '0;
      end
      invalid_count <= '0;
    end else begin
      if (valid_ev && (hist[dec_digit] != CNT_MAX)) begin
        hist[dec_digit] <= hist[dec_digit] + CNT_W'(1);
      end
      if (invalid_ev && (invalid_count != CNT_MAX)) begin
        invalid_count <= invalid_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
    end else begin
      rd_count <= hist[rd_sel];
    end
  end

endmodule

// File: tb/tb_seg_decode_monitor.sv
// Directed bench for seg_decode_monitor with a history-based reference model
// and hand-computed pinned expectations.
module tb_seg_decode_monitor;

  localparam int S     = 2;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;
  localparam int HLEN  = 4096;

  localparam int ID_DIG  = 0;
  localparam int ID_DV   = 1;
  localparam int ID_INV  = 2;
  localparam int ID_RD   = 3;
  localparam int ID_ICNT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic          clear;
  logic [2:0]    rd_sel;
  logic [2:0]    digit;
  logic          digit_valid;
  logic          invalid;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] invalid_count;

  seg_decode_monitor #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .seg           (seg),
    .clear         (clear),
    .rd_sel        (rd_sel),
    .digit         (digit),
    .digit_valid   (digit_valid),
    .invalid       (invalid),
    .rd_count      (rd_count),
    .invalid_count (invalid_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] samp [HLEN];
  int         nsamp = 0;
  logic       live  = 1'b0;
  int         m_digit = 0;
  int         m_dv = 0;
  int         m_inv = 0;
  int         m_rd = 0;
  int         m_icnt = 0;
  int         m_cnt [8];

  function automatic int lookup(input logic [6:0] p);
    case (p)
      7'b1111110: return 0;
      7'b0110000: return 1;
      7'b1101101: return 2;
      7'b1111001: return 3;
      7'b0110011: return 4;
      7'b1011011: return 5;
      7'b1011111: return 6;
      7'b1110000: return 7;
      default:    return -1;
    endcase
  endfunction

  // Samples before the reset boundary read as all-zero.
  function automatic logic [6:0] sample_at(input int idx);
    if (idx < 0) return 7'b0000000;
    return samp[idx % HLEN];
  endfunction

  // An event occurs on the edge completing the first S equal samples of a run.
  always @(posedge clk) begin
    automatic logic [6:0] p;
    automatic logic       ev;
    automatic int         d;
    automatic logic       nv;
    automatic logic       ni;
    if (rst) begin
      live   <= 1'b1;
      nsamp  <= 0;
      m_digit <= 0;
      m_dv   <= 0;
      m_inv  <= 0;
      m_rd   <= 0;
      m_icnt <= 0;
      for (int i = 0; i < 8; i++) m_cnt[i] <= 0;
    end else begin
      p  = seg;
      ev = 1'b1;
      for (int j = 1; j < S; j++) begin
        if (sample_at(nsamp - j) != p) ev = 1'b0;
      end
      if (sample_at(nsamp - S) == p) ev = 1'b0;
      d  = lookup(p);
      nv = ev && (d >= 0);
      ni = ev && (d < 0) && (p != 7'b0000000);
      m_dv  <= nv ? 1 : 0;
      m_inv <= ni ? 1 : 0;
      if (nv) m_digit <= d;
      m_rd <= m_cnt[rd_sel];
      if (clear) begin
        for (int i = 0; i < 8; i++) m_cnt[i] <= 0;
        m_icnt <= 0;
      end else begin
        if (nv && m_cnt[d] < MAXC) m_cnt[d] <= m_cnt[d] + 1;
        if (ni && m_icnt < MAXC) m_icnt <= m_icnt + 1;
      end
      samp[nsamp % HLEN] <= p;
      nsamp <= nsamp + 1;
    end
  end

  // ---------------- pinned expectations ----------------
  int    pin_id  [$];
  int    pin_val [$];
  string pin_nm  [$];

  task automatic pin(input int id, input int val, input string nm);
    pin_id.push_back(id);
    pin_val.push_back(val);
    pin_nm.push_back(nm);
  endtask

  // ---------------- compare process ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int pin_rd   = 0;

  function automatic int dut_val(input int id);
    case (id)
      ID_DIG:  return int'(digit);
      ID_DV:   return int'(digit_valid);
      ID_INV:  return int'(invalid);
      ID_RD:   return int'(rd_count);
      default: return int'(invalid_count);
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      check("digit",         dut_val(ID_DIG),  m_digit);
      check("digit_valid",   dut_val(ID_DV),   m_dv);
      check("invalid",       dut_val(ID_INV),  m_inv);
      check("rd_count",      dut_val(ID_RD),   m_rd);
      check("invalid_count", dut_val(ID_ICNT), m_icnt);
      check("pulse_exclusive", int'(digit_valid && invalid), 0);
      while (pin_rd < pin_id.size()) begin
        check(pin_nm[pin_rd], dut_val(pin_id[pin_rd]), pin_val[pin_rd]);
        pin_rd++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; seg = 7'b0000000; clear = 1'b0; rd_sel = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    pin(ID_DIG, 0, "idle_digit"); pin(ID_DV, 0, "idle_dv");
    pin(ID_RD, 0, "idle_rd");     pin(ID_ICNT, 0, "idle_icnt");

    // digit 2 held 5 samples
    @(negedge clk); seg = 7'b1101101; rd_sel = 3'd2;
    @(posedge clk);
    @(posedge clk); #1;
    pin(ID_DV, 1, "dec2_pulse"); pin(ID_DIG, 2, "dec2_digit"); pin(ID_INV, 0, "dec2_noinv");
    @(posedge clk); #1;
    pin(ID_DV, 0, "dec2_single"); pin(ID_RD, 1, "dec2_rd");
    repeat (3) @(negedge clk); seg = 7'b0000000;
    repeat (2) @(negedge clk);

    // one-sample glitch of 3 between runs of 1
    rd_sel = 3'd3; seg = 7'b0110000;
    repeat (3) @(negedge clk); seg = 7'b1111001;
    @(negedge clk);            seg = 7'b0110000;
    repeat (3) @(negedge clk); seg = 7'b0000000;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    pin(ID_RD, 0, "glitch_bin3"); pin(ID_DIG, 1, "glitch_digit");
    @(negedge clk); rd_sel = 3'd1;
    @(posedge clk); #1;
    pin(ID_RD, 2, "glitch_bin1");

    // invalid pattern held 3 samples
    @(negedge clk); seg = 7'b1000000;
    @(posedge clk);
    @(posedge clk); #1;
    pin(ID_INV, 1, "inv_pulse"); pin(ID_DV, 0, "inv_nodv");
    pin(ID_ICNT, 1, "inv_count"); pin(ID_DIG, 1, "inv_digit_held");
    @(posedge clk); #1;
    pin(ID_INV, 0, "inv_single");
    @(negedge clk); seg = 7'b0000000;
    repeat (2) @(negedge clk);

    // one digit-0 event, then a digit-0 event coinciding with clear
    rd_sel = 3'd0; seg = 7'b1111110;
    repeat (3) @(negedge clk); seg = 7'b0000000;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    pin(ID_RD, 1, "bin0_before_clear");
    @(negedge clk); seg = 7'b1111110;
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    pin(ID_DV, 1, "clear_pulse"); pin(ID_DIG, 0, "clear_digit"); pin(ID_ICNT, 0, "clear_icnt");
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;
    pin(ID_RD, 0, "clear_bin0");
    @(negedge clk); seg = 7'b0000000;
    repeat (3) @(negedge clk);

    // 20 digit-0 runs separated by blanks saturate a 4-bit bin
    for (int r = 0; r < 20; r++) begin
      seg = 7'b1111110;
      repeat (2) @(negedge clk);
      seg = 7'b0000000;
      repeat (2) @(negedge clk);
    end
    @(posedge clk); #1;
    pin(ID_RD, 15, "sat_bin0");

    // reset one sample into a digit-4 run
    @(negedge clk); seg = 7'b0110011;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    pin(ID_DV, 0, "rst_nodv"); pin(ID_DIG, 0, "rst_digit"); pin(ID_RD, 0, "rst_rd");
    @(negedge clk); rst = 1'b0; seg = 7'b0000000;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      pin(ID_DV, 0, "post_rst_nodv");
      pin(ID_INV, 0, "post_rst_noinv");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_decode_monitor.md
# seg_decode_monitor

Receive-side counterpart of the seven-segment digit encoder: samples the 7-bit active-high segment bus `{a,b,c,d,e,f,g}` and decodes it back to a 3-bit digit. It emits one event per stable pattern and keeps saturating per-digit and invalid-pattern histograms. It sits beside the PRNG→display path as an on-chip monitor, used to check display integrity and PRNG digit distribution.

## Interface
- `STABLE_CYCLES`, default 2: consecutive identical samples needed to accept a pattern; legal range 2..255.
- `CNT_W`, default 16: width of every histogram counter.

- `clk` input 1: system clock.
- `rst` input 1: reset; synchronous, active-high.
- `seg` input 7: observed segments `{a,b,c,d,e,f,g}`, active HIGH.
- `clear` input 1: synchronous clear of all counters.
- `rd_sel` input 3: histogram bin select.
- `digit` output 3: last accepted digit; holds between events.
- `digit_valid` output 1: one-cycle pulse when a valid digit is accepted.
- `invalid` output 1: one-cycle pulse when a non-blank, non-digit pattern is accepted.
- `rd_count` output CNT_W: registered count for bin `rd_sel`.
- `invalid_count` output CNT_W: count of invalid events.

## Operation
- Legal patterns, which must match the encoder exactly:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
- Blank pattern 0000000 is neither valid nor invalid. It produces no event and no count.
- Every other pattern is invalid.
- Sampling:
  - `seg_q <= seg` every cycle.
  - `run_len` is 8 bits. If `seg != seg_q`, then `run_len <= 1`. Otherwise it increments, saturating at `STABLE_CYCLES`.
- Acceptance fires when `seg == seg_q` and `run_len == STABLE_CYCLES-1`. The pattern is decoded and a pulse is registered for the next cycle.
- Acceptance fires exactly once per stable run. Back-to-back identical digits with no intervening change merge into one event; this is by design.
- Counters:
  - 8 digit bins plus the invalid counter, each CNT_W wide.
  - Each increments by 1 on its event and saturates at all-ones; no wrap.
- `clear` zeroes all counters next cycle. If `clear` and an event coincide, clear wins: the pulse and `digit` update still occur, but nothing is counted.
- A glitch shorter than `STABLE_CYCLES` samples produces no event. The run restarts on the next change.

## Timing
- Reset values: `seg_q`=0, `run_len`=0, `digit`=0, `digit_valid`=0, `invalid`=0, all counters 0, `rd_count`=0, `invalid_count`=0.
- Event latency:
  - A new pattern first captured into `seg_q` at edge k produces its pulse (and the `digit` update) registered at edge k+STABLE_CYCLES-1.
  - The counter update lands on the same edge as the pulse.
- `rd_count <= hist[rd_sel]` with 1-cycle latency. It reflects counter values as of the previous edge.
- `invalid_count` is a direct register output.
- `rst` mid-run discards any partial run and clears all state in the same cycle. There are no pulses in the cycle after reset.
- `digit_valid` and `invalid` are never high together.

## Structure
- Shared package `seg_pkg`:
  - `SEG_W`=7
  - `SEG_DIGIT0`..`SEG_DIGIT7`
  - `SEG_BLANK`
- The encoder is refactored to use the same package constants so that both ends cannot drift.
- Sub-module `seg_pattern_decode` (combinational): `seg` → `{is_digit, is_blank, digit[2:0]}`.
- Top level holds the sampler, run counter, event registers and histogram. Target 150–250 lines of RTL.

## Test plan
- Reset/idle: assert `rst` 2 cycles with `seg`=0000000 held 20 cycles → all outputs 0, no pulses, all counts 0.
- Valid decode, `STABLE_CYCLES`=2:
  - Stimulus: `seg`=1101101 held 5 cycles.
  - Required: exactly one `digit_valid` 2 edges after first capture, `digit`=2; with `rd_sel`=2, `rd_count`=1 one cycle later.
- Glitch rejection: 1111001 for 1 cycle between 0110000 runs → only digit-1 events counted; bin 3 stays 0.
- Invalid pattern: `seg`=1000000 held 3 cycles → one `invalid` pulse, `invalid_count`=1, `digit` unchanged.
- Saturation, `CNT_W`=4: 20 alternating stable runs of 0 and blank → bin 0 reads 15.
- Clear and reset collisions:
  - `clear` asserted on the cycle an event is accepted → pulse is seen, bin reads 0.
  - `rst` asserted mid-run with `run_len`=1 → no event follows.
